// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: walks a combinational ROM into a 2-entry {pc, instr} queue,
// honours branch redirects and latches a sticky fault on out-of-range or misaligned fetch targets.
module ifetch_ctrl #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          MEM_WORDS = 32
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] rom_addr,
   input  logic [31:0] rom_data,
   output logic        out_valid,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   input  logic        out_ready,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        fault,
   output logic [31:0] fault_pc
);

   typedef enum logic {ST_RUN, ST_FAULT} state_t;

   state_t      r_state;
   state_t      w_nextState;
   logic [31:0] r_fetchPc;
   logic [1:0]  r_count;
   logic [31:0] r_pc0;
   logic [31:0] r_instr0;
   logic [31:0] r_pc1;
   logic [31:0] r_instr1;
   logic [31:0] r_faultPc;

   logic        w_pop;
   logic        w_inRange;
   logic        w_fetch;
   logic        w_misaligned;

   assign rom_addr     = {2'b00, r_fetchPc[31:2]};
   assign w_inRange    = rom_addr < 32'(MEM_WORDS);
   assign w_misaligned = redirect_pc[1:0] != 2'b00;
   // A redirect wins over everything else in its cycle, so it suppresses both pop and fetch.
   assign w_pop        = (r_count != 2'd0) && out_ready && !redirect_valid;
   assign w_fetch      = (r_state == ST_RUN) && !redirect_valid && w_inRange &&
                         ((r_count != 2'd2) || w_pop);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_RUN;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      if (redirect_valid) begin
         w_nextState = w_misaligned ? ST_FAULT : ST_RUN;
      end else if ((r_state == ST_RUN) && !w_inRange) begin
         w_nextState = ST_FAULT;
      end
   end

   always_comb begin
      out_valid = r_count != 2'd0;
      out_instr = out_valid ? r_instr0 : 32'h0;
      out_pc    = out_valid ? r_pc0 : 32'h0;
      fault     = r_state == ST_FAULT;
      fault_pc  = r_faultPc;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_fetchPc <= RESET_PC;
         r_count   <= 2'd0;
         r_pc0     <= 32'h0;
         r_instr0  <= 32'h0;
         r_pc1     <= 32'h0;
         r_instr1  <= 32'h0;
         r_faultPc <= 32'h0;
      end else if (redirect_valid) begin
         r_count   <= 2'd0;
         r_fetchPc <= redirect_pc;
         r_faultPc <= w_misaligned ? redirect_pc : 32'h0;
      end else begin
         if ((r_state == ST_RUN) && !w_inRange) begin
            r_faultPc <= r_fetchPc;
         end
         if (w_fetch) begin
            r_fetchPc <= r_fetchPc + 32'd4;
         end
         // Slot 0 is always the head; a pop shifts slot 1 forward before any new word lands.
         case ({w_pop, w_fetch})
            2'b10: begin
               r_pc0    <= r_pc1;
               r_instr0 <= r_instr1;
               r_count  <= r_count - 2'd1;
            end
            2'b01: begin
               if (r_count == 2'd0) begin
                  r_pc0    <= r_fetchPc;
                  r_instr0 <= rom_data;
               end else begin
                  r_pc1    <= r_fetchPc;
                  r_instr1 <= rom_data;
               end
               r_count <= r_count + 2'd1;
            end
            2'b11: begin
               if (r_count == 2'd1) begin
                  r_pc0    <= r_fetchPc;
                  r_instr0 <= rom_data;
               end else begin
                  r_pc0    <= r_pc1;
                  r_instr0 <= r_instr1;
                  r_pc1    <= r_fetchPc;
                  r_instr1 <= rom_data;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: doc/ifetch_ctrl.md
IFETCH_CTRL -- requirements
Module: ifetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, byte address of the first fetched instruction.
REQ-002 Parameter MEM_WORDS, default 32, number of 32-bit words in the attached instruction ROM.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 rom_addr  output  32  word index to the ROM, equal to fetch_pc >> 2, zero-extended.
REQ-006 rom_data  input  32  combinational ROM read data for rom_addr, valid in the same cycle.
REQ-007 out_valid  output  1  queue head holds a valid instruction.
REQ-008 out_instr  output  32  instruction word at the queue head.
REQ-009 out_pc  output  32  byte address of out_instr.
REQ-010 out_ready  input  1  decode consumes the head when out_valid && out_ready (pop).
REQ-011 redirect_valid  input  1  one-cycle branch/jump redirect request.
REQ-012 redirect_pc  input  32  target byte address of the redirect.
REQ-013 fault  output  1  sticky fetch fault flag.
REQ-014 fault_pc  output  32  address that caused the fault.

Function
REQ-015 The block SHALL hold fetch_pc and a 2-entry FIFO of {pc, instr} pairs, plus FSM states RUN and FAULT.
REQ-016 In RUN, the block SHALL fetch (enqueue {fetch_pc, rom_data}, fetch_pc += 4) when count < 2, or when count == 2 and a pop occurs in the same cycle.
REQ-017 Fetch latency SHALL be one cycle: a word fetched in cycle N is visible on out_instr/out_pc with out_valid=1 in cycle N+1.
REQ-018 Pop and fetch in the same cycle SHALL leave count unchanged, preserving FIFO order.
REQ-019 out_valid SHALL equal (count != 0); out_instr/out_pc SHALL be 0 when count == 0.
REQ-020 fetch_pc SHALL wrap modulo 2^32 on increment.
REQ-021 When fetch_pc >> 2 >= MEM_WORDS, the block SHALL NOT enqueue and SHALL enter FAULT with fault=1 and fault_pc=fetch_pc on the next edge; instructions already queued remain poppable.
REQ-022 In FAULT, no fetches SHALL occur; fault and fault_pc SHALL hold.
REQ-023 redirect_valid SHALL take priority over pop and fetch in that cycle: FIFO flushed (count=0), fetch_pc <= redirect_pc, no enqueue; out_valid=0 the following cycle.
REQ-024 A redirect with redirect_pc[1:0] != 0 SHALL flush the FIFO, enter FAULT, set fault=1 and fault_pc=redirect_pc.
REQ-025 An aligned redirect in FAULT SHALL clear fault, zero fault_pc, and return to RUN, fetching redirect_pc the next cycle.
REQ-026 Pop when out_valid=0 SHALL have no effect; count SHALL never exceed 2 or underflow.

Reset
REQ-027 While reset=1, regardless of clk: fetch_pc=RESET_PC, count=0, state RUN, out_valid=0, out_instr=0, out_pc=0, fault=0, fault_pc=0.
REQ-028 The first fetch SHALL occur in the first cycle after reset deasserts; reset asserted mid-operation SHALL discard queued instructions immediately.

Verification
REQ-029 Reset release, ROM words k*0x11, out_ready=1 -> out_pc 0,4,8,... one per cycle from cycle 1, out_instr 0x00,0x11,0x22.
REQ-030 out_ready=0 for 5 cycles -> count saturates at 2, fetch_pc stops at 8, heads 0 and 4 then emitted in order once out_ready=1.
REQ-031 Queue full, redirect_valid with redirect_pc=0x40 in same cycle as pop -> next cycle out_valid=0, then out_pc=0x40, 0x44.
REQ-032 MEM_WORDS=4, sequential run -> pcs 0..0xC delivered, fault=1, fault_pc=0x10, no further fetches.
REQ-033 redirect_pc=0x06 -> fault=1, fault_pc=0x06, out_valid=0; then redirect_pc=0x08 -> fault=0, out_pc=0x08 two cycles later.
REQ-034 reset asserted asynchronously with count=2 -> out_valid=0 and fault=0 before next clk edge; resumes at RESET_PC.
